// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for a 5-stage pipeline. It drives the enable and
//   flush/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   It resolves three hazard classes, highest priority first:
//     1. data-memory stall: req/ready handshake, with a timeout
//     2. taken branch in EX
//     3. load-use between the load in EX and the instruction in ID
//   All controls are combinational from state and inputs, so a hazard seen
//   in a cycle governs the capture at the end of that same cycle.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   id_rs1/id_rs2       ID-stage source register addresses
//   id_uses_rs2         ID instruction reads rs2
//   ex_mem_read, ex_rd  load in EX and its destination register
//   ex_branch_taken     EX resolved a taken branch or jump
//   mem_access          MEM holds a load or store
//   dmem_ready          data memory completes the access this cycle
//   dmem_req            data-memory request
//   pc_en .. mem_wb_en  pipeline-register capture enables
//   if_id_flush         IF/ID loads a NOP
//   id_ex_flush         ID/EX loads a bubble
//   mem_wb_bubble       MEM/WB captures RegWrite=0, MemtoReg=0
//   mem_timeout         sticky memory-timeout error flag
//   stall_cycles        saturating count of cycles with the PC held
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

    localparam int              WC_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_stall;
    logic            load_use;

    assign mem_stall = (state != MEM_ERR) && mem_access && !dmem_ready;

    // x0 is hardwired to zero, so a load into x0 never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        state_nxt     = state;
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;

        if (reset || (state == MEM_ERR)) begin
            // Freeze everything: no capture, no request.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            dmem_req = mem_access;
            if (mem_stall) begin
                // Hold the front of the pipe. WB drains a bubble so that the
                // stalled instruction is not written back twice.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                // Redirect the PC. Killing IF/ID and ID/EX also removes any
                // load-use dependent, so load-use is not considered here.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end

            // Leaving MEM_WAIT on ready or on a dropped mem_access both
            // appear here as "no stall".
            if (mem_stall)
                state_nxt = (wait_cnt == WC_LAST) ? MEM_ERR : MEM_WAIT;
            else
                state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (!mem_stall)
                wait_cnt <= '0;
            else if (wait_cnt != WC_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            if ((state != MEM_ERR) && !pc_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;

            if (state_nxt == MEM_ERR)
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives enable and flush/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three hazard classes: load-use, taken branch, and variable-latency data-memory access (req/ready handshake with timeout).
- Sits beside the datapath; receives hazard information from the ID, EX and MEM stages.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive not-ready memory cycles allowed before the error state (>=1).
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  ID-stage source register 1 address.
- id_rs2  in  5  ID-stage source register 2 address.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX (ID/EX output) is a load.
- ex_rd  in  5  EX-stage destination register address.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_access  in  1  instruction in MEM is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID capture enable.
- if_id_flush  out  1  IF/ID load NOP.
- id_ex_en  out  1  ID/EX capture enable.
- id_ex_flush  out  1  ID/EX load bubble (all control bits 0).
- ex_mem_en  out  1  EX/MEM capture enable.
- mem_wb_en  out  1  MEM/WB capture enable.
- mem_wb_bubble  out  1  MEM/WB captures RegWrite=0, MemtoReg=0.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  saturating count of PC-stalled cycles.

Behaviour:
- FSM states: RUN, MEM_WAIT, MEM_ERR; state register and counters update on clk rising edge.
- Reset (sync, high): state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
- While reset is high, all combinational outputs are forced to 0: every enable, every flush, mem_wb_bubble, dmem_req.
- Outputs other than mem_timeout/stall_cycles are combinational from state and inputs. Zero added latency: a hazard seen in cycle N controls the capture at the end of cycle N.
- mem_stall = (state != MEM_ERR) && mem_access && !dmem_ready.
- dmem_req = mem_access && state != MEM_ERR.
- Priority: mem_stall > ex_branch_taken > load-use.
- Default (no hazard, RUN/MEM_WAIT): all *_en = 1, flushes = 0, bubble = 0.
- mem_stall active:
  - pc_en = if_id_en = id_ex_en = ex_mem_en = 0.
  - mem_wb_en = 1, mem_wb_bubble = 1, so WB drains and the stalled instruction is never written twice.
  - Branch and load-use inputs are ignored; they re-evaluate once unfrozen.
- Taken branch (no mem_stall): if_id_flush = 1, id_ex_flush = 1, pc_en = 1 (redirect). Overrides a simultaneous load-use, because the dependent instruction is killed.
- Load-use condition: ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)).
- Load-use action: pc_en = 0, if_id_en = 0, id_ex_flush = 1; EX/MEM and MEM/WB advance. Exactly one bubble per load-use, since next cycle the load has left EX.
- RUN -> MEM_WAIT when mem_stall.
- MEM_WAIT -> RUN on a cycle with dmem_ready = 1. That cycle is unfrozen, and MEM/WB captures the data with bubble = 0.
- MEM_WAIT holds while mem_access && !dmem_ready.
- MEM_WAIT -> RUN also if mem_access drops; this is protocol misuse but must not hang.
- wait_cnt:
  - Counts consecutive cycles with mem_stall, including the first RUN cycle.
  - Clears on any cycle without mem_stall.
  - Saturates at TIMEOUT_CYCLES.
- Timeout: when mem_stall holds and wait_cnt == TIMEOUT_CYCLES-1, the next state is MEM_ERR and mem_timeout sets.
- MEM_ERR: all enables 0, flushes 0, bubble 0, dmem_req 0, mem_timeout = 1. Exits only through reset.
- stall_cycles increments by 1 on every cycle with pc_en == 0 outside reset and MEM_ERR; it holds at all-ones.
- Reset asserted mid-wait or in MEM_ERR: next cycle is RUN with all counters and flags cleared.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5) with id_rs1=5 -> exactly one cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Next cycle, with ex_mem_read=0, all enables=1; stall_cycles=1.
- ex_rd=0 with id_rs1=0, ex_mem_read=1 -> no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1; no load-use stall.
- mem_access=1, dmem_ready low for 3 cycles then high (TIMEOUT_CYCLES=16):
  - 3 cycles of pc_en=ex_mem_en=0 with mem_wb_bubble=1.
  - 4th cycle all enables=1 with bubble=0.
  - stall_cycles=3; state back to RUN.
- TIMEOUT_CYCLES=4, mem_access=1, dmem_ready never high:
  - After 4 stalled cycles mem_timeout=1 and state MEM_ERR; all enables 0, dmem_req=0.
  - Asserting reset for 1 cycle clears mem_timeout and stall_cycles.
- CNT_W=4 with 20 consecutive load-use/memory stalls -> stall_cycles saturates at 15.
- Reset asserted during MEM_WAIT -> outputs 0 that cycle; RUN state next cycle.
